multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-style sequencer that turns the single-cycle MIPS datapath into a multicycle datapath. It shares one unified memory, one ALU and the PC adder across FETCH/DECODE/EXECUTE/MEM/WB steps. It sits beside the datapath and drives every mux select and enable. Memory accesses use a ready handshake so slow memory stalls the sequence.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag, combinational from current ALU operation
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC register enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  1  A3 select: 0 = instr[20:16], 1 = instr[15:11]
mem_to_reg  out  1  WD3 select: 0 = ALUOut, 1 = memory data register
reg_write  out  1  register file WE3
alu_src_a  out  1  0 = PC, 1 = RD1 register
alu_src_b  out  2  00 = RD2 register, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
alu_control  out  5  ALU select, encodings from the package
pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
state  out  4  current state, for the testbench
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (reset_n = 0, async) forces state to FETCH and retired to 0. All outputs are decoded from state (plus zero/mem_ready where noted), so during reset the FETCH values apply: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_source=00, all other outputs 0. pc_en and ir_write are 0 while reset_n = 0.
- Reset mid-operation abandons the instruction. No write strobe may be asserted in the cycle reset asserts; they are gated by reset_n.
- States and transitions:
- FETCH: mem_read, iord=0; ALU computes PC+4. On mem_ready: ir_write=1, pc_en=1, next state DECODE. Otherwise hold FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - LW 100011 or SW 101011 -> MEMADR
  - R-type 000000 -> EXEC
  - BEQ 000100 -> BRANCH
  - ADDI 001000 -> ADDIEX
  - J 000010 -> JUMP
  - any other opcode -> FETCH (NOP)
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write, mem_to_reg=1, reg_dst=0. Next state FETCH; retired increments.
- MEMWR: mem_write, iord=1. Hold until mem_ready, then FETCH; retired increments. mem_write stays high for every stall cycle.
- EXEC: alu_src_a=1, alu_src_b=00. alu_control from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; unknown funct -> ADD. Next state ALUWB.
- ALUWB: reg_write, reg_dst=1, mem_to_reg=0. Next state FETCH; retired increments.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en=zero. Next state FETCH; retired increments.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. Next state ADDIWB.
- ADDIWB: reg_write, reg_dst=0, mem_to_reg=0. Next state FETCH; retired increments.
- JUMP: pc_source=10, pc_en=1. Next state FETCH; retired increments.
- retired wraps modulo 2^CNT_W. NOP-decoded instructions do not count.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- mem_read and mem_write are never both 1.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: adds output illegal_instr (1 bit) and state TRAP. An unknown opcode in DECODE goes to TRAP, which holds forever with all enables 0 and illegal_instr=1. Only reset_n exits TRAP. Unknown funct in EXEC also goes to TRAP.
- Undefined: no port and no state; unknown opcode -> FETCH as a NOP, unknown funct -> ADD.

Decomposition:
- Package mc_pkg holds:
  - state enum (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12
  - opcode and funct localparams
  - ALU select constants: AND=5'd0, OR=5'd1, ADD=5'd2, SUB=5'd6, SLT=5'd7
  - alu_src_b and pc_source encodings
- One sub-module, mc_alu_decoder: combinational mapping of funct to alu_control plus a valid flag; reused by the top-level datapath.

Test Plan:
- mem_ready=1 always, opcode 000000, funct 100000 -> states 0,1,6,7,0. reg_write=1, reg_dst=1 only in ALUWB; retired=1 after 4 cycles.
- LW with mem_ready low for 3 cycles in MEMRD -> MEMRD held 3 cycles with mem_read=1, iord=1, then MEMWB with mem_to_reg=1. Sequence is 4+3 cycles after FETCH.
- BEQ with zero=1, then with zero=0 -> pc_en=1 with pc_source=01 in BRANCH only when zero=1; alu_control=SUB (6) both times.
- SW with mem_ready delayed 2 cycles -> mem_write high 3 consecutive cycles and never together with mem_read; reg_write stays 0.
- reset_n asserted low mid-MEMWR -> state=0 immediately, mem_write=0, retired=0. After release, FETCH resumes.
- Opcode 111111 -> returns to FETCH and retired unchanged (macro off); with ILLEGAL_TRAP_EN, state=12, illegal_instr=1 held until reset_n low.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: states, opcodes, functs,
// ALU selects and datapath mux codes. Optional build macro: ILLEGAL_TRAP_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd6;
  localparam logic [4:0] ALU_SLT = 5'd7;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU select. Unknown functs decode to ADD with valid low so
// callers can choose between a silent ADD and a trap.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer driving the shared-memory multicycle MIPS datapath.
// Build macro ILLEGAL_TRAP_EN adds illegal_instr and a sticky TRAP state.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [4:0]       alu_control,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal_instr,
`endif
  output logic [CNT_W-1:0] retired
);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_retired;
  logic               w_pc_en, w_mem_write, w_ir_write, w_reg_write, w_retire;
  logic [4:0]         w_fn_alu;
  logic               w_fn_ok;

  mc_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (w_fn_alu),
    .valid       (w_fn_ok)
  );

`ifndef ILLEGAL_TRAP_EN
  logic w_unused_fn_ok;
  assign w_unused_fn_ok = w_fn_ok;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_en     = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    pc_source   = PCSRC_ALU;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_en    = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = TRAP;
`else
          default:      w_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end
      MEMWR: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = FETCH;
        end
      end
      EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_fn_alu;
        w_next      = ALUWB;
`ifdef ILLEGAL_TRAP_EN
        if (!w_fn_ok) w_next = TRAP;
`endif
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = PCSRC_ALUOUT;
        w_pc_en     = zero;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = ADDIWB;
      end
      ADDIWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end
      JUMP: begin
        pc_source = PCSRC_JUMP;
        w_pc_en   = 1'b1;
        w_retire  = 1'b1;
        w_next    = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegal_instr = 1'b1;
        w_next        = TRAP;
      end
`endif
      default: w_next = FETCH;
    endcase
  end

  // Strobes are masked by reset_n so an abandoned instruction cannot write.
  assign pc_en     = w_pc_en     & reset_n;
  assign ir_write  = w_ir_write  & reset_n;
  assign reg_write = w_reg_write & reset_n;
  assign mem_write = w_mem_write & reset_n;
  assign state     = r_state;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of single instructions, hand-written stall
// and reset sequences, and random instruction streams against a per-instruction model.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic [5:0]    opcode = '0, funct = '0;
  logic          zero = 1'b0, mem_ready = 1'b0;
  logic          pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic [4:0]    alu_control;
  logic [3:0]    state;
  logic [CW-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic          illegal_instr;
`endif

  multicycle_control #(.CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_source(pc_source), .state(state),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_control;
    logic [1:0] pc_source;
  } outs_t;

  typedef struct {
    logic [5:0]  opc, fn;
    logic        z;
    int          n;
    logic [23:0] path;  // state i in nibble i, leftmost first
    int          ret;
  } vec_t;

  int errs = 0, checks = 0, model_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20: return 5'd2;
      6'h22: return 5'd6;
      6'h24: return 5'd0;
      6'h25: return 5'd1;
      6'h2a: return 5'd7;
      default: return 5'd2;
    endcase
  endfunction

  // Expected outputs per step; c marks the mux fields that step defines.
  function automatic void exp_outs(input int st, input logic [5:0] fn, input logic z,
                                   input logic mr, output outs_t e, output outs_t c);
    e = '0; c = '0;
    c.pc_en = 1; c.mem_read = 1; c.mem_write = 1; c.ir_write = 1; c.reg_write = 1;
    case (st)
      0: begin
        e.mem_read = 1; e.ir_write = mr; e.pc_en = mr; e.alu_src_b = 2'b01; e.alu_control = 5'd2;
        c.iord = 1; c.alu_src_a = 1; c.alu_src_b = '1; c.alu_control = '1; c.pc_source = '1;
      end
      1: begin
        e.alu_src_b = 2'b11; e.alu_control = 5'd2;
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_control = '1;
      end
      2, 9: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 5'd2;
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_control = '1;
      end
      3: begin e.mem_read = 1; e.iord = 1; c.iord = 1; end
      4: begin e.reg_write = 1; e.mem_to_reg = 1; c.mem_to_reg = 1; c.reg_dst = 1; end
      5: begin e.mem_write = 1; e.iord = 1; c.iord = 1; end
      6: begin
        e.alu_src_a = 1; e.alu_control = alu_of(fn);
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_control = '1;
      end
      7: begin e.reg_write = 1; e.reg_dst = 1; c.reg_dst = 1; c.mem_to_reg = 1; end
      8: begin
        e.alu_src_a = 1; e.alu_control = 5'd6; e.pc_source = 2'b01; e.pc_en = z;
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_control = '1; c.pc_source = '1;
      end
      10: begin e.reg_write = 1; c.reg_dst = 1; c.mem_to_reg = 1; end
      11: begin e.pc_source = 2'b10; e.pc_en = 1; c.pc_source = '1; end
      default: ;
    endcase
  endfunction

  // One clock: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic step(input int exp_st, input logic mr, input logic z);
    outs_t a, e, c;
    mem_ready = mr; zero = z;
    @(negedge clock);
    chk($sformatf("state(exp %0d)", exp_st), 32'(state), 32'(exp_st));
    chk($sformatf("retired@st%0d", exp_st), 32'(retired), 32'(model_ret % (1 << CW)));
    exp_outs(exp_st, funct, z, mr, e, c);
    a = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
         alu_src_a, alu_src_b, alu_control, pc_source};
    chk($sformatf("outputs@st%0d", exp_st), 32'(a & c), 32'(e & c));
    @(posedge clock); #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: expected walk for one instruction given stall counts.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fst, input int mst);
    logic retires;
    opcode = opc; funct = fn; retires = 1'b1;
    for (int f = 0; f < fst; f++) step(0, 1'b0, rb());
    step(0, 1'b1, rb());
    step(1, rb(), rb());
    case (opc)
      6'h23: begin
        step(2, rb(), rb());
        for (int m = 0; m < mst; m++) step(3, 1'b0, rb());
        step(3, 1'b1, rb());
        step(4, rb(), rb());
      end
      6'h2b: begin
        step(2, rb(), rb());
        for (int m = 0; m < mst; m++) step(5, 1'b0, rb());
        step(5, 1'b1, rb());
      end
      6'h00: begin step(6, rb(), rb()); step(7, rb(), rb()); end
      6'h04: step(8, rb(), rb());
      6'h08: begin step(9, rb(), rb()); step(10, rb(), rb()); end
      6'h02: step(11, rb(), rb());
      default: retires = 1'b0;
    endcase
    if (retires) model_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [5:0] opcs[7];
    logic [5:0] fns[6];
    vecs.push_back('{6'h00, 6'h20, 1'b0, 4, 24'h016700, 1});
    vecs.push_back('{6'h00, 6'h22, 1'b0, 4, 24'h016700, 1});
    vecs.push_back('{6'h00, 6'h24, 1'b1, 4, 24'h016700, 1});
    vecs.push_back('{6'h00, 6'h25, 1'b0, 4, 24'h016700, 1});
    vecs.push_back('{6'h00, 6'h2a, 1'b0, 4, 24'h016700, 1});
    vecs.push_back('{6'h04, 6'h00, 1'b1, 3, 24'h018000, 1});
    vecs.push_back('{6'h04, 6'h00, 1'b0, 3, 24'h018000, 1});
    vecs.push_back('{6'h08, 6'h00, 1'b0, 4, 24'h019A00, 1});
    vecs.push_back('{6'h02, 6'h00, 1'b1, 3, 24'h01B000, 1});
    vecs.push_back('{6'h23, 6'h00, 1'b0, 5, 24'h012340, 1});
    vecs.push_back('{6'h2b, 6'h00, 1'b0, 4, 24'h012500, 1});
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back('{6'h00, 6'h3f, 1'b0, 4, 24'h016700, 1});
    vecs.push_back('{6'h3f, 6'h00, 1'b0, 2, 24'h010000, 0});
`endif

    // Reset state, with mem_ready high to show the strobes stay masked.
    mem_ready = 1'b1;
    #2;
    chk("reset state", 32'(state), 0);
    chk("reset retired", 32'(retired), 0);
    chk("reset pc_en", 32'(pc_en), 0);
    chk("reset ir_write", 32'(ir_write), 0);
    chk("reset mem_read", 32'(mem_read), 1);
    chk("reset alu_src_b", 32'(alu_src_b), 1);
    chk("reset alu_control", 32'(alu_control), 2);
    @(posedge clock); #1;
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      opcode = vecs[k].opc; funct = vecs[k].fn;
      for (int i = 0; i < vecs[k].n; i++)
        step(int'(vecs[k].path[23 - 4*i -: 4]), 1'b1, vecs[k].z);
      model_ret += vecs[k].ret;
    end

    run_instr(6'h23, 6'h00, 1, 3);  // LW, slow fetch and slow read
    run_instr(6'h2b, 6'h00, 0, 2);  // SW, write held three cycles

    // Reset during a stalled store.
    opcode = 6'h2b; funct = 6'h00;
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0); step(2, 1'b1, 1'b0); step(5, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("midreset state", 32'(state), 0);
    chk("midreset mem_write", 32'(mem_write), 0);
    chk("midreset retired", 32'(retired), 0);
    chk("midreset pc_en", 32'(pc_en), 0);
    model_ret = 0;
    #1 reset_n = 1'b1;
    run_instr(6'h00, 6'h20, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    opcode = 6'h3f; funct = 6'h00;
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(12, 1'b1, 1'b1);
      chk("illegal_instr", 32'(illegal_instr), 1);
    end
    @(negedge clock) reset_n = 1'b0;
    #1 chk("trap reset state", 32'(state), 0);
    model_ret = 0;
    @(posedge clock); #1 reset_n = 1'b1;
`endif

    opcs = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3f};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
    for (int n = 0; n < 80; n++) begin
`ifdef ILLEGAL_TRAP_EN
      run_instr(opcs[$urandom_range(0, 5)], fns[$urandom_range(0, 4)],
                $urandom_range(0, 2), $urandom_range(0, 3));
`else
      run_instr(opcs[$urandom_range(0, 6)], fns[$urandom_range(0, 5)],
                $urandom_range(0, 2), $urandom_range(0, 3));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
